// File: rtl/im_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package im_pkg;

    localparam logic [23:0] IM_BASE_HI = 24'h760000;
    localparam int unsigned IM_WORDS   = 64;

    typedef enum logic {
        M_FETCH = 1'b0,
        M_LOAD  = 1'b1
    } im_master_e;

    typedef enum logic {
        StIdle = 1'b0,
        StResp = 1'b1
    } im_state_e;

endpackage

// File: rtl/im_arb_pick.sv
// Grant selection between fetch (m0) and loader (m1).
// Fixed priority to m0 by default; round-robin when IM_ARB_RR_EN is defined.
module im_arb_pick (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic stall_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef IM_ARB_RR_EN
    // prio_q = 1 means m1 wins the next tie
    logic prio_q, prio_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (rstn_i && !stall_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = !prio_q;
                gnt1_o = prio_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
        prio_d = prio_q;
        if (gnt0_o) begin
            prio_d = 1'b1;
        end else if (gnt1_o) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rstn_i;

    always_comb begin
        gnt0_o = rstn_i && !stall_i && req0_i;
        gnt1_o = rstn_i && !stall_i && req1_i && !req0_i;
    end
`endif

endmodule

// File: rtl/im_arbiter.sv
// Two-requester arbiter in front of a combinational instruction memory.
// Registered one-cycle responses; round-robin selection with IM_ARB_RR_EN.
module im_arbiter
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [23:0] BASE_HI = IM_BASE_HI
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic              m1_err_o,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rd_i
);

    logic              gnt0, gnt1, granted, addr_err, rvalid;
    logic [ADDR_W-1:0] sel_addr;
    im_master_e        sel_id;

    im_state_e         state_q, state_d;
    im_master_e        rid_q, rid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    im_arb_pick u_pick (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req0_i  (m0_req_i),
        .req1_i  (m1_req_i),
        .stall_i (stall_i),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    assign granted  = gnt0 | gnt1;
    assign sel_id   = gnt1 ? M_LOAD : M_FETCH;
    assign sel_addr = gnt1 ? m1_addr_i : m0_addr_i;
    // Window check assumes ADDR_W >= 32
    assign addr_err = (sel_addr[31:8] != BASE_HI) || (sel_addr[1:0] != 2'b00);

    always_comb begin
        state_d     = StIdle;
        rid_d       = rid_q;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
        last_addr_d = last_addr_q;
        if (granted) begin
            state_d     = StResp;
            rid_d       = sel_id;
            err_d       = addr_err;
            rdata_d     = addr_err ? 32'd0 : mem_rd_i;
            last_addr_d = sel_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            rid_q       <= M_FETCH;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign rvalid = (state_q == StResp);

    always_comb begin
        m0_gnt_o    = gnt0;
        m1_gnt_o    = gnt1;
        m0_rvalid_o = rvalid && (rid_q == M_FETCH);
        m1_rvalid_o = rvalid && (rid_q == M_LOAD);
        m0_err_o    = m0_rvalid_o && err_q;
        m1_err_o    = m1_rvalid_o && err_q;
        m0_rdata_o  = m0_rvalid_o ? rdata_q : 32'd0;
        m1_rdata_o  = m1_rvalid_o ? rdata_q : 32'd0;
        mem_addr_o  = granted ? sel_addr : last_addr_q;
    end

endmodule

// File: tb/tb_im_arbiter.sv
// Directed table-driven bench for im_arbiter; expectations follow IM_ARB_RR_EN.
module tb_im_arbiter;

`ifdef IM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m1_req, stall;
    logic [31:0] m0_addr, m1_addr, mem_rd;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata, mem_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    im_arbiter dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .m0_req_i    (m0_req),
        .m0_addr_i   (m0_addr),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m0_err_o    (m0_err),
        .m1_req_i    (m1_req),
        .m1_addr_i   (m1_addr),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .m1_err_o    (m1_err),
        .stall_i     (stall),
        .mem_addr_o  (mem_addr),
        .mem_rd_i    (mem_rd)
    );

    typedef struct {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic [31:0] m1_addr;
        logic        stall;
        logic [31:0] mem_rd;
        logic [1:0]  gnt;     // {m1, m0}
        logic [1:0]  rvalid;  // {m1, m0}
        logic [1:0]  err;     // {m1, m0}
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        logic [31:0] mem_addr;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic [31:0] a0, input logic r1,
                                input logic [31:0] a1, input logic st, input logic [31:0] rd,
                                input logic [1:0] g, input logic [1:0] rv, input logic [1:0] e,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] ma);
        vec_t v;
        v.m0_req = r0; v.m0_addr = a0; v.m1_req = r1; v.m1_addr = a1;
        v.stall = st; v.mem_rd = rd; v.gnt = g; v.rvalid = rv; v.err = e;
        v.rdata0 = d0; v.rdata1 = d1; v.mem_addr = ma;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic [1:0] rv,
                             input logic [1:0] e, input logic [31:0] d0,
                             input logic [31:0] d1, input logic [31:0] ma);
        check({tag, " gnt"}, {62'd0, m1_gnt, m0_gnt}, {62'd0, g});
        check({tag, " rvalid/err"}, {60'd0, m1_rvalid, m0_rvalid, m1_err, m0_err},
              {60'd0, rv, e});
        check({tag, " rdata"}, {m1_rdata, m0_rdata}, {d1, d0});
        check({tag, " mem_addr"}, {32'd0, mem_addr}, {32'd0, ma});
    endtask

    localparam logic [31:0] A0 = 32'h7600_0000;
    localparam logic [31:0] A1 = 32'h7600_0010;

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(1, 32'h7600_0004, 0, 0, 0, 32'hDEAD_BEEF,
                          2'b01, 2'b00, 2'b00, 0, 0, 32'h7600_0004));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h1234_5678,
                          2'b00, 2'b01, 2'b00, 32'hDEAD_BEEF, 0, 32'h7600_0004));
        // Contention: last grant was m0, so round-robin hands the first tie to m1
        vecs.push_back(mk(1, A0, 1, A1, 0, 32'h1111_1111,
                          RR ? 2'b10 : 2'b01, 2'b00, 2'b00, 0, 0, RR ? A1 : A0));
        vecs.push_back(mk(1, A0, 1, A1, 0, 32'h2222_2222, 2'b01, RR ? 2'b10 : 2'b01, 2'b00,
                          RR ? 32'd0 : 32'h1111_1111, RR ? 32'h1111_1111 : 32'd0, A0));
        vecs.push_back(mk(1, A0, 1, A1, 0, 32'h3333_3333, RR ? 2'b10 : 2'b01, 2'b01, 2'b00,
                          32'h2222_2222, 0, RR ? A1 : A0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, RR ? 2'b10 : 2'b01, 2'b00,
                          RR ? 32'd0 : 32'h3333_3333, RR ? 32'h3333_3333 : 32'd0,
                          RR ? A1 : A0));
        // Error responses on m1: bad window, then misaligned
        vecs.push_back(mk(0, 0, 1, 32'h7700_0000, 0, 32'hAAAA_AAAA,
                          2'b10, 2'b00, 2'b00, 0, 0, 32'h7700_0000));
        vecs.push_back(mk(0, 0, 1, 32'h7600_0002, 0, 32'hBBBB_BBBB,
                          2'b10, 2'b10, 2'b10, 0, 0, 32'h7600_0002));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'hCCCC_CCCC,
                          2'b00, 2'b10, 2'b10, 0, 0, 32'h7600_0002));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 32'h7600_0002));
        // Stall: pending response still delivered, grant only after stall drops
        vecs.push_back(mk(1, 32'h7600_0020, 0, 0, 0, 32'h4444_4444,
                          2'b01, 2'b00, 2'b00, 0, 0, 32'h7600_0020));
        vecs.push_back(mk(1, 32'h7600_0024, 0, 0, 1, 32'h5555_5555,
                          2'b00, 2'b01, 2'b00, 32'h4444_4444, 0, 32'h7600_0020));
        vecs.push_back(mk(1, 32'h7600_0024, 0, 0, 1, 32'h5555_5555,
                          2'b00, 2'b00, 2'b00, 0, 0, 32'h7600_0020));
        vecs.push_back(mk(1, 32'h7600_0024, 0, 0, 1, 32'h5555_5555,
                          2'b00, 2'b00, 2'b00, 0, 0, 32'h7600_0020));
        vecs.push_back(mk(1, 32'h7600_0024, 0, 0, 0, 32'h6666_6666,
                          2'b01, 2'b00, 2'b00, 0, 0, 32'h7600_0024));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 32'h6666_6666, 0,
                          32'h7600_0024));
        // Four back-to-back fetches
        vecs.push_back(mk(1, 32'h7600_0030, 0, 0, 0, 32'h70, 2'b01, 2'b00, 2'b00, 0, 0,
                          32'h7600_0030));
        vecs.push_back(mk(1, 32'h7600_0034, 0, 0, 0, 32'h71, 2'b01, 2'b01, 2'b00, 32'h70, 0,
                          32'h7600_0034));
        vecs.push_back(mk(1, 32'h7600_0038, 0, 0, 0, 32'h72, 2'b01, 2'b01, 2'b00, 32'h71, 0,
                          32'h7600_0038));
        vecs.push_back(mk(1, 32'h7600_003C, 0, 0, 0, 32'h73, 2'b01, 2'b01, 2'b00, 32'h72, 0,
                          32'h7600_003C));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 32'h73, 0, 32'h7600_003C));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 32'h7600_003C));

        // Reset with a request pending: grants forced low
        rstn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; stall = 1'b0;
        m0_addr = A0; m1_addr = A1; mem_rd = 32'hFFFF_FFFF;
        #2;
        check_all("reset", 2'b00, 2'b00, 2'b00, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1; m0_req = 1'b0; m1_req = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            m0_req = vecs[i].m0_req; m0_addr = vecs[i].m0_addr;
            m1_req = vecs[i].m1_req; m1_addr = vecs[i].m1_addr;
            stall  = vecs[i].stall;  mem_rd  = vecs[i].mem_rd;
            #4;
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rvalid, vecs[i].err,
                      vecs[i].rdata0, vecs[i].rdata1, vecs[i].mem_addr);
            @(posedge clk); #1;
        end

        // Reset pulsed in the cycle after a grant drops the response
        m0_req = 1'b1; m0_addr = 32'h7600_0040; mem_rd = 32'h9999_9999;
        #4;
        check("rst_seq gnt", {63'd0, m0_gnt}, 64'd1);
        @(posedge clk); #1;
        check("rst_seq rvalid pre", {31'd0, m0_rvalid, m0_rdata}, {31'd0, 1'b1, 32'h9999_9999});
        rstn = 1'b0; m1_req = 1'b1;
        #1;
        check_all("rst_mid", 2'b00, 2'b00, 2'b00, 0, 0, 0);
        @(posedge clk); #1;
        rstn = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        #3;
        check("rst_rel rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
        @(posedge clk); #1;
        check("rst_rel rvalid2", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);

        // Pointer back to m0 after reset even though m0 was granted last
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = A0; m1_addr = A1; mem_rd = 32'h5A5A_5A5A;
        #4;
        check("post_rst tie gnt", {62'd0, m1_gnt, m0_gnt}, 64'd1);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        #3;
        check("post_rst resp", {31'd0, m0_rvalid, m0_rdata}, {31'd0, 1'b1, 32'h5A5A_5A5A});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/im_arbiter.md
IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter BASE_HI, default 24'h760000, required value of addr[31:8] for the instruction-memory window.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req_i / m1_req_i  input  1  read request (m0 = fetch, m1 = loader/debug).
REQ-006 SHALL have ports m0_addr_i / m1_addr_i  input  ADDR_W  byte address of request.
REQ-007 SHALL have ports m0_gnt_o / m1_gnt_o  output  1  request accepted this cycle.
REQ-008 SHALL have ports m0_rvalid_o / m1_rvalid_o  output  1  response valid.
REQ-009 SHALL have ports m0_rdata_o / m1_rdata_o  output  32  response data.
REQ-010 SHALL have ports m0_err_o / m1_err_o  output  1  response is an error, qualified by rvalid.
REQ-011 SHALL have port stall_i  input  1  freeze, no new grants.
REQ-012 SHALL have port mem_addr_o  output  ADDR_W  address to the combinational instruction memory.
REQ-013 SHALL have port mem_rd_i  input  32  memory read data, valid same cycle as mem_addr_o.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt is combinational from req, stall_i and arbitration state.
REQ-015 SHALL grant no requester while stall_i=1; a response already pending is still delivered.
REQ-016 SHALL drive mem_addr_o with the granted requester's address; with no grant, it holds the last granted address.
REQ-017 SHALL register the response: rvalid, rdata and err appear exactly one cycle after gnt, on the granted requester's port only, for one cycle.
REQ-018 SHALL support back-to-back grants: a grant may occur in the same cycle a previous response is presented (throughput 1/cycle).
REQ-019 SHALL flag error when addr[31:8] != BASE_HI or addr[1:0] != 0; an error response has err=1 and rdata=32'd0.
REQ-020 SHALL drive rdata=32'd0 whenever rvalid=0.
REQ-021 SHALL implement a two-state FSM: IDLE (no response pending) and RESP (response pending); IDLE->RESP on grant; RESP->RESP on grant; RESP->IDLE without grant.
REQ-022 SHALL require requesters to hold req and addr stable until gnt; a withdrawn request SHALL NOT be remembered.
REQ-023 SHALL, without IM_ARB_RR_EN, use fixed priority: m0 wins when both requests are asserted in the same cycle.

Reset
REQ-024 SHALL, while rstn_i=0, force all gnt, rvalid and err outputs to 0, rdata to 0, mem_addr_o to 0, the FSM to IDLE and the RR pointer to favour m0.
REQ-025 SHALL drop a pending response if reset asserts mid-operation; no rvalid after release until a new grant.

Configuration
REQ-026 SHALL compile round-robin arbitration when the macro IM_ARB_RR_EN is defined.
REQ-027 Under IM_ARB_RR_EN, on simultaneous requests the requester not granted most recently SHALL win; the pointer SHALL update only on a grant.
REQ-028 Without IM_ARB_RR_EN, there SHALL be no pointer register and arbitration SHALL be fixed priority per REQ-023.

Structure
REQ-029 SHALL take IM_BASE_HI (24'h760000), IM_WORDS (64) and the requester index enum (M_FETCH=0, M_LOAD=1) from shared package im_pkg.
REQ-030 SHALL place the grant selection (fixed or RR) in sub-module im_arb_pick; the FSM, error check and response register stay in im_arbiter.

Verification
REQ-031 Reset, then m0_req=1, addr 0x76000004, mem_rd=0xDEADBEEF -> m0_gnt same cycle; next cycle m0_rvalid=1, rdata=0xDEADBEEF, err=0.
REQ-032 m0 and m1 request every cycle (0x76000000, 0x76000010): without the macro -> m0 granted every cycle, m1 starved; with IM_ARB_RR_EN -> grants alternate m0, m1, m0, ...
REQ-033 m1 addr 0x77000000, then 0x76000002 -> m1_rvalid=1, err=1, rdata=0 for each.
REQ-034 Request held with stall_i=1 for 3 cycles -> no gnt; gnt in the first cycle after stall_i falls; a pending response during the stall is still delivered.
REQ-035 rstn_i pulsed low in the cycle after a grant -> no rvalid follows; all outputs 0 during reset.
REQ-036 m0 requests 4 consecutive cycles -> 4 grants and 4 responses, each one cycle later; FSM stays in RESP and returns to IDLE once requests stop.
